// File: rtl/rename_stage.sv
// Register rename stage: speculative/architectural RATs, one circular free list,
// WIDTH-wide in-order renaming with intra-group bypass and single-cycle flush.
module rename_stage #(
  parameter int WIDTH     = 2,
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 64,
  localparam int AW = $clog2(NUM_AREGS),
  localparam int PW = $clog2(NUM_PREGS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [WIDTH-1:0]              dec_valid_i,
  input  logic [WIDTH-1:0]              dec_has_dst_i,
  input  logic [WIDTH-1:0][AW-1:0]      dec_src1_i,
  input  logic [WIDTH-1:0][AW-1:0]      dec_src2_i,
  input  logic [WIDTH-1:0][AW-1:0]      dec_dst_i,
  output logic                          dec_ready_o,
  output logic [WIDTH-1:0]              disp_valid_o,
  output logic [WIDTH-1:0][PW-1:0]      disp_src1_o,
  output logic [WIDTH-1:0][PW-1:0]      disp_src2_o,
  output logic [WIDTH-1:0][PW-1:0]      disp_dst_o,
  output logic [WIDTH-1:0][PW-1:0]      disp_old_o,
  input  logic                          disp_ready_i,
  input  logic [WIDTH-1:0]              free_valid_i,
  input  logic [WIDTH-1:0][PW-1:0]      free_preg_i,
  input  logic [WIDTH-1:0]              cmt_valid_i,
  input  logic [WIDTH-1:0]              cmt_has_dst_i,
  input  logic [WIDTH-1:0][AW-1:0]      cmt_areg_i,
  input  logic [WIDTH-1:0][PW-1:0]      cmt_preg_i,
  input  logic                          flush_i
);

  typedef logic [PW:0] ptr_t;

  logic [PW-1:0] spec_rat_q [NUM_AREGS];
  logic [PW-1:0] spec_rat_d [NUM_AREGS];
  logic [PW-1:0] arch_rat_q [NUM_AREGS];
  logic [PW-1:0] arch_rat_d [NUM_AREGS];
  logic [PW-1:0] fl_q       [NUM_PREGS];

  ptr_t rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d;
  ptr_t free_cnt, alloc_cnt;

  logic [WIDTH-1:0]         alloc;
  logic [WIDTH-1:0][PW-1:0] new_preg, src1_d, src2_d, dst_d, old_d, free_idx;
  logic                     accept;

  logic [WIDTH-1:0]         disp_valid_q;
  logic [WIDTH-1:0][PW-1:0] disp_src1_q, disp_src2_q, disp_dst_q, disp_old_q;

  assign free_cnt    = wr_ptr_q - rd_ptr_q;
  assign dec_ready_o = rst_ni & ~flush_i & (free_cnt >= ptr_t'(WIDTH))
                     & (~|disp_valid_q | disp_ready_i);
  assign accept      = dec_ready_o & (|dec_valid_i);

  // Rename: each lane sees the youngest older lane's new mapping before the RAT.
  always_comb begin
    ptr_t off;
    off = '0;
    for (int k = 0; k < WIDTH; k++) begin
      alloc[k]    = dec_valid_i[k] & dec_has_dst_i[k] & (dec_dst_i[k] != '0);
      new_preg[k] = fl_q[rd_ptr_q[PW-1:0] + off[PW-1:0]];
      src1_d[k]   = spec_rat_q[dec_src1_i[k]];
      src2_d[k]   = spec_rat_q[dec_src2_i[k]];
      old_d[k]    = spec_rat_q[dec_dst_i[k]];
      for (int j = 0; j < k; j++) begin
        if (alloc[j] && dec_dst_i[j] == dec_src1_i[k]) src1_d[k] = new_preg[j];
        if (alloc[j] && dec_dst_i[j] == dec_src2_i[k]) src2_d[k] = new_preg[j];
        if (alloc[j] && dec_dst_i[j] == dec_dst_i[k])  old_d[k]  = new_preg[j];
      end
      if (dec_src1_i[k] == '0) src1_d[k] = '0;
      if (dec_src2_i[k] == '0) src2_d[k] = '0;
      dst_d[k] = alloc[k] ? new_preg[k] : '0;
      if (!alloc[k]) old_d[k] = '0;
      off = off + ptr_t'(alloc[k]);
    end
    alloc_cnt = off;
  end

  // Frees, commits and next-state RATs/pointers.
  always_comb begin
    ptr_t fo, co;
    fo = '0;
    co = '0;
    arch_rat_d = arch_rat_q;
    for (int k = 0; k < WIDTH; k++) begin
      free_idx[k] = wr_ptr_q[PW-1:0] + fo[PW-1:0];
      fo = fo + ptr_t'(free_valid_i[k]);
      if (cmt_valid_i[k] && cmt_has_dst_i[k] && cmt_areg_i[k] != '0) begin
        arch_rat_d[cmt_areg_i[k]] = cmt_preg_i[k];
        co = co + ptr_t'(1);
      end
    end
    wr_ptr_d  = wr_ptr_q + fo;
    cmt_ptr_d = cmt_ptr_q + co;
    spec_rat_d = spec_rat_q;
    if (flush_i) spec_rat_d = arch_rat_d;
    else if (accept) begin
      for (int k = 0; k < WIDTH; k++)
        if (alloc[k]) spec_rat_d[dec_dst_i[k]] = new_preg[k];
    end
    if (flush_i)     rd_ptr_d = cmt_ptr_d;
    else if (accept) rd_ptr_d = rd_ptr_q + alloc_cnt;
    else             rd_ptr_d = rd_ptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int a = 0; a < NUM_AREGS; a++) begin
        spec_rat_q[a] <= PW'(a);
        arch_rat_q[a] <= PW'(a);
      end
      for (int i = 0; i < NUM_PREGS; i++)
        fl_q[i] <= (i < NUM_PREGS - NUM_AREGS) ? PW'(NUM_AREGS + i) : '0;
      rd_ptr_q     <= '0;
      cmt_ptr_q    <= '0;
      wr_ptr_q     <= ptr_t'(NUM_PREGS - NUM_AREGS);
      disp_valid_q <= '0;
      disp_src1_q  <= '0;
      disp_src2_q  <= '0;
      disp_dst_q   <= '0;
      disp_old_q   <= '0;
    end else begin
      spec_rat_q <= spec_rat_d;
      arch_rat_q <= arch_rat_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      for (int k = 0; k < WIDTH; k++)
        if (free_valid_i[k]) fl_q[free_idx[k]] <= free_preg_i[k];
      if (flush_i) disp_valid_q <= '0;
      else if (accept) begin
        disp_valid_q <= dec_valid_i;
        disp_src1_q  <= src1_d;
        disp_src2_q  <= src2_d;
        disp_dst_q   <= dst_d;
        disp_old_q   <= old_d;
      end else if (disp_ready_i) disp_valid_q <= '0;
    end
  end

  assign disp_valid_o = disp_valid_q;
  assign disp_src1_o  = disp_src1_q;
  assign disp_src2_o  = disp_src2_q;
  assign disp_dst_o   = disp_dst_q;
  assign disp_old_o   = disp_old_q;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage at WIDTH=4: bypass chains, holes, stall,
// free-list exhaustion/refill and flush with same-cycle commit.
module tb_rename_stage;
  localparam int W = 4, NA = 32, NP = 64, AW = 5, PW = 6;

  logic clk = 1'b0, rst_n;
  logic [W-1:0]         dv, dhd;
  logic [W-1:0][AW-1:0] ds1, ds2, dd;
  logic                 dec_ready;
  logic [W-1:0]         disp_valid;
  logic [W-1:0][PW-1:0] s1, s2, dst, old;
  logic                 disp_ready;
  logic [W-1:0]         fv;
  logic [W-1:0][PW-1:0] fp;
  logic [W-1:0]         cv, chd;
  logic [W-1:0][AW-1:0] ca;
  logic [W-1:0][PW-1:0] cp;
  logic                 flush;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  rename_stage #(.WIDTH(W), .NUM_AREGS(NA), .NUM_PREGS(NP)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dec_valid_i(dv), .dec_has_dst_i(dhd), .dec_src1_i(ds1), .dec_src2_i(ds2),
    .dec_dst_i(dd), .dec_ready_o(dec_ready),
    .disp_valid_o(disp_valid), .disp_src1_o(s1), .disp_src2_o(s2),
    .disp_dst_o(dst), .disp_old_o(old), .disp_ready_i(disp_ready),
    .free_valid_i(fv), .free_preg_i(fp),
    .cmt_valid_i(cv), .cmt_has_dst_i(chd), .cmt_areg_i(ca), .cmt_preg_i(cp),
    .flush_i(flush)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    dv = '0; dhd = '0; ds1 = '0; ds2 = '0; dd = '0;
  endtask

  task automatic lane(input int k, input logic v, input logic hd, input int d, input int a, input int b);
    dv[k] = v; dhd[k] = hd; dd[k] = AW'(d); ds1[k] = AW'(a); ds2[k] = AW'(b);
  endtask

  task automatic do_reset();
    idle();
    fv = '0; fp = '0; cv = '0; chd = '0; ca = '0; cp = '0;
    flush = 1'b0; disp_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values and a two-lane dependent group
    do_reset();
    check("rst_vld", int'(disp_valid), 0);
    check("rst_dst0", int'(dst[0]), 0);
    check("rst_rdy", int'(dec_ready), 1);
    lane(0, 1, 1, 5, 0, 0);
    lane(1, 1, 1, 6, 5, 5);
    tick();
    check("g1_vld", int'(disp_valid), 3);
    check("g1_src0", int'(s1[0]), 0);
    check("g1_dst0", int'(dst[0]), 32);
    check("g1_old0", int'(old[0]), 5);
    check("g1_dst1", int'(dst[1]), 33);
    check("g1_src1_1", int'(s1[1]), 32);
    check("g1_src2_1", int'(s2[1]), 32);
    check("g1_old1", int'(old[1]), 6);
    idle();
    tick();
    check("g1_drain", int'(disp_valid), 0);

    // Every lane reads and writes x7: full chain through the group
    do_reset();
    for (int k = 0; k < W; k++) lane(k, 1, 1, 7, 7, 7);
    tick();
    for (int k = 0; k < W; k++) begin
      check("chain_dst", int'(dst[k]), 32 + k);
      check("chain_src", int'(s1[k]), (k == 0) ? 7 : 31 + k);
      check("chain_old", int'(old[k]), (k == 0) ? 7 : 31 + k);
    end
    idle();
    lane(0, 1, 0, 0, 7, 5);
    tick();
    check("rat_x7", int'(s1[0]), 35);
    check("rat_x5", int'(s2[0]), 5);
    check("nodst_dst", int'(dst[0]), 0);
    check("nodst_old", int'(old[0]), 0);

    // Hole and x0 destination
    do_reset();
    lane(0, 1, 1, 3, 1, 2);
    lane(1, 0, 1, 9, 0, 0);
    lane(2, 1, 1, 0, 3, 0);
    lane(3, 1, 1, 4, 3, 0);
    tick();
    check("hole_vld", int'(disp_valid), 13);
    check("hole_dst0", int'(dst[0]), 32);
    check("hole_old0", int'(old[0]), 3);
    check("hole_dst2", int'(dst[2]), 0);
    check("hole_old2", int'(old[2]), 0);
    check("hole_src2", int'(s1[2]), 32);
    check("hole_dst3", int'(dst[3]), 33);
    check("hole_old3", int'(old[3]), 4);

    // Dispatch stall holds outputs and blocks the next group
    disp_ready = 1'b0;
    idle();
    lane(0, 1, 1, 8, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_rdy", int'(dec_ready), 0);
      tick();
      check("stall_vld", int'(disp_valid), 13);
      check("stall_dst3", int'(dst[3]), 33);
    end
    disp_ready = 1'b1;
    #1;
    check("unstall_rdy", int'(dec_ready), 1);
    tick();
    check("unstall_vld", int'(disp_valid), 1);
    check("unstall_dst0", int'(dst[0]), 34);
    check("unstall_old0", int'(old[0]), 8);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_vld", int'(disp_valid), 0);
    check("async_rdy", int'(dec_ready), 0);

    // Drain free list below WIDTH, then refill one entry
    do_reset();
    for (int g = 0; g < 7; g++) begin
      for (int k = 0; k < W; k++) lane(k, 1, 1, k + 1, 0, 0);
      tick();
    end
    idle();
    lane(0, 1, 1, 1, 0, 0);
    tick();
    idle();
    #1;
    check("empty_rdy", int'(dec_ready), 0);
    fv[0] = 1'b1;
    fp[0] = PW'(5);
    #1;
    check("free_same_rdy", int'(dec_ready), 0);
    tick();
    fv = '0;
    check("refill_rdy", int'(dec_ready), 1);
    for (int k = 0; k < W; k++) lane(k, 1, 1, k + 1, 0, 0);
    tick();
    check("wrap_dst0", int'(dst[0]), 61);
    check("wrap_dst2", int'(dst[2]), 63);
    check("wrap_dst3", int'(dst[3]), 5);

    // Flush with a same-cycle commit of x5
    do_reset();
    lane(0, 1, 1, 5, 0, 0);
    lane(1, 1, 1, 6, 0, 0);
    tick();
    idle();
    lane(0, 1, 1, 9, 0, 0);
    disp_ready = 1'b0;
    flush = 1'b1;
    cv[0] = 1'b1; chd[0] = 1'b1; ca[0] = AW'(5); cp[0] = PW'(32);
    #1;
    check("flush_rdy", int'(dec_ready), 0);
    tick();
    flush = 1'b0; cv = '0; chd = '0; ca = '0; cp = '0;
    disp_ready = 1'b1;
    check("flush_vld", int'(disp_valid), 0);
    idle();
    lane(0, 1, 0, 0, 5, 6);
    lane(1, 1, 1, 9, 0, 0);
    #1;
    check("post_flush_rdy", int'(dec_ready), 1);
    tick();
    check("flush_x5", int'(s1[0]), 32);
    check("flush_x6", int'(s2[0]), 6);
    check("flush_alloc", int'(dst[1]), 33);
    check("flush_old9", int'(old[1]), 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
